instruction_encoder: RTL and testbench
======================================

Name: instruction_encoder

Overview:
- Inverse of the datapath immediate extractor: packs an immediate value into the 8-bit instruction word, using the same 2-bit format select.
- Range-checks each immediate against its field; out-of-range requests are rejected and not written.
- Writes encoded words sequentially into program memory (combinational read, synchronous write).
- Used by the program loader and by testbenches.

Parameters:
- ADDR_W, 5, program memory address width; DEPTH = 2**ADDR_W words.

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous reset, active-low
- clr_addr  in  1  synchronous clear of write pointer, count and full
- in_valid  in  1  request valid
- in_ready  out  1  encoder can accept a request
- fmt  in  2  00 = ADDI/SUBI/MOVA, 01 = SR0/SRH0, 10 = BR/BRZ, 11 = MOV
- base  in  8  instruction bits outside the immediate field (opcode/register)
- imm_in  in  8  immediate value, two's complement for fmt 10
- pm_we  out  1  program memory write enable
- pm_addr  out  ADDR_W  program memory address
- pm_wdata  out  8  encoded instruction
- pm_rdata  in  8  program memory read data (combinational); used only with readback
- err_range  out  1  1-cycle pulse: request rejected, immediate out of range
- err_verify  out  1  1-cycle pulse: readback mismatch
- full  out  1  DEPTH words written
- count  out  ADDR_W+1  words written since reset/clear

Behaviour:
- Reset (reset_n = 0 at a rising edge): state IDLE; pm_we = 0, pm_addr = 0, pm_wdata = 0, err_* = 0, full = 0, count = 0. Reset overrides everything, including mid-operation: any pending write is dropped.
- States: IDLE, ENCODE, WRITE, plus VERIFY with the macro.
- IDLE: in_ready = 1 when !full && !clr_addr, else 0. A handshake (in_valid & in_ready) registers fmt, base and imm_in, then moves to ENCODE. in_ready is 0 in every other state.
- ENCODE (1 cycle): range check and packing.
  - fmt 00: legal if imm_in[7:3] = 0; word = {base[7:5], imm_in[2:0], base[1:0]}.
  - fmt 01: legal if imm_in[7:4] = 0; word = {base[7:4], imm_in[3:0]}.
  - fmt 10: legal if imm_in[7:5] = {3{imm_in[4]}} (-16..+15); word = {base[7:5], imm_in[4:0]}.
  - fmt 11: legal if imm_in = 0; word = base.
  - Legal: register word into pm_wdata, go to WRITE.
  - Illegal: err_range = 1 for this cycle only, go to IDLE; no write, pointer unchanged.
- WRITE (1 cycle): pm_we = 1, pm_addr = wr_ptr. At the end of the cycle, wr_ptr and count increment.
  - wr_ptr wraps DEPTH-1 -> 0.
  - full sets when count reaches DEPTH.
  - Next state is IDLE (no macro) or VERIFY (macro).
- pm_we is asserted only in WRITE.
- Latency: handshake at edge N; pm_we high during cycle N+2; in_ready high again at cycle N+3 (N+4 with readback).
- clr_addr: acts in IDLE only; sets wr_ptr = 0, count = 0, full = 0. It is held pending (not lost) while a write is in flight, and is applied on the next IDLE cycle.
- Round-trip invariant: for every legal request, extracting the immediate from pm_wdata with the same fmt gives imm_in (zero-extended for 00/01, sign-extended for 10, 0x00 for 11).

Optional Feature:
- Macro: ENC_READBACK_EN.
- Defined: after WRITE, state VERIFY (1 cycle).
  - pm_addr is held at the just-written address; pm_we = 0.
  - If pm_rdata != pm_wdata, err_verify pulses for 1 cycle.
  - count and full are unaffected.
  - Next state IDLE.
- Not defined: no VERIFY state; err_verify is tied to 0 and pm_rdata is ignored.

Test Plan:
- Reset, then fmt 00, base 0xA3, imm 5 -> pm_we at cycle N+2, pm_addr 0, pm_wdata 0xB7, count 1.
- fmt 10, base 0xC0, imm 0xF0 (-16) -> pm_wdata 0xD0; then imm 0x10 (+16) -> err_range pulse, no pm_we, count unchanged.
- fmt 01, imm 0x10 -> err_range; fmt 11, imm 0x01 -> err_range; fmt 11, base 0x5A, imm 0 -> pm_wdata 0x5A.
- 32 back-to-back legal writes (ADDR_W = 5) -> full = 1, count 32, in_ready = 0; pulse clr_addr -> next write at pm_addr 0.
- reset_n low during WRITE cycle -> pm_we is 0 from the next cycle, count 0, state IDLE.
- With ENC_READBACK_EN: memory model corrupts one bit -> err_verify pulse one cycle after pm_we; clean memory -> no pulse.

Source files
------------

// File: rtl/instruction_encoder_if.sv
// instruction_encoder_if
//   Request handshake and program-memory bus between the program loader (or a
//   testbench) and instruction_encoder.
//
//   Request side : in_valid, in_ready, fmt, base, imm_in
//   Memory side  : pm_we, pm_addr, pm_wdata, pm_rdata
//
//   modport slave  : the encoder (accepts requests, drives the memory bus)
//   modport master : the requester plus memory (drives requests and pm_rdata)
interface instruction_encoder_if #(
  parameter int unsigned ADDR_W = 5
);

  logic              in_valid;
  logic              in_ready;
  logic [1:0]        fmt;
  logic [7:0]        base;
  logic [7:0]        imm_in;

  logic              pm_we;
  logic [ADDR_W-1:0] pm_addr;
  logic [7:0]        pm_wdata;
  logic [7:0]        pm_rdata;

  modport master (
    output in_valid,
    output fmt,
    output base,
    output imm_in,
    output pm_rdata,
    input  in_ready,
    input  pm_we,
    input  pm_addr,
    input  pm_wdata
  );

  modport slave (
    input  in_valid,
    input  fmt,
    input  base,
    input  imm_in,
    input  pm_rdata,
    output in_ready,
    output pm_we,
    output pm_addr,
    output pm_wdata
  );

endinterface

// File: rtl/instruction_encoder.sv
// instruction_encoder
//   Packs an immediate into an 8-bit instruction word (inverse of the datapath
//   immediate extractor) and writes the words sequentially into program memory.
//   Out-of-range immediates are rejected with a one-cycle err_range pulse and
//   nothing is written.
//
//   fmt 00 ADDI/SUBI/MOVA : imm 0..7,    word = {base[7:5], imm[2:0], base[1:0]}
//   fmt 01 SR0/SRH0       : imm 0..15,   word = {base[7:4], imm[3:0]}
//   fmt 10 BR/BRZ         : imm -16..15, word = {base[7:5], imm[4:0]}
//   fmt 11 MOV            : imm == 0,    word = base
//
//   Ports
//     clk        system clock
//     reset_n    synchronous reset, active-low
//     clr_addr   clear write pointer, count and full (applied in IDLE)
//     bus        instruction_encoder_if.slave (request + program memory bus)
//     err_range  1-cycle pulse, request rejected (immediate out of range)
//     err_verify 1-cycle pulse, readback mismatch (0 without readback)
//     full       DEPTH words written
//     count      words written since reset/clear
//
//   Optional feature: define ENC_READBACK_EN to add a VERIFY cycle after each
//   write that compares pm_rdata against the written word.
module instruction_encoder #(
  parameter int unsigned ADDR_W = 5
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                clr_addr,
  instruction_encoder_if.slave bus,
  output logic                err_range,
  output logic                err_verify,
  output logic                full,
  output logic [ADDR_W:0]     count
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] LAST_COUNT = (ADDR_W + 1)'(DEPTH - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ENCODE = 2'd1;
  localparam logic [1:0] S_WRITE  = 2'd2;
`ifdef ENC_READBACK_EN
  localparam logic [1:0] S_VERIFY = 2'd3;
`endif

  logic [1:0]        state;
  logic [1:0]        fmt_q;
  logic [7:0]        base_q;
  logic [7:0]        imm_q;
  logic [7:0]        wdata_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W:0]   count_q;
  logic              full_q;
  logic              clr_pend;

  logic              legal;
  logic [7:0]        word;
  logic              ready;
  logic              handshake;

  // Range check and field packing on the registered request.
  always_comb begin
    legal = 1'b0;
    word  = '0;
    case (fmt_q)
      2'b00: begin
        legal = (imm_q[7:3] == 5'd0);
        word  = {base_q[7:5], imm_q[2:0], base_q[1:0]};
      end
      2'b01: begin
        legal = (imm_q[7:4] == 4'd0);
        word  = {base_q[7:4], imm_q[3:0]};
      end
      2'b10: begin
        legal = (imm_q[7:5] == {3{imm_q[4]}});
        word  = {base_q[7:5], imm_q[4:0]};
      end
      default: begin
        legal = (imm_q == 8'd0);
        word  = base_q;
      end
    endcase
  end

  assign ready     = (state == S_IDLE) && !full_q && !clr_addr;
  assign handshake = bus.in_valid && ready;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      fmt_q    <= '0;
      base_q   <= '0;
      imm_q    <= '0;
      wdata_q  <= '0;
      addr_q   <= '0;
      wr_ptr   <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      clr_pend <= 1'b0;
    end else begin
      // A clear arriving while a request is in flight is remembered and
      // applied on the next IDLE cycle, after the pending write has counted.
      if (state != S_IDLE && clr_addr) begin
        clr_pend <= 1'b1;
      end

      case (state)
        S_IDLE: begin
          if (clr_addr || clr_pend) begin
            wr_ptr   <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            clr_pend <= 1'b0;
          end
          if (handshake) begin
            fmt_q  <= bus.fmt;
            base_q <= bus.base;
            imm_q  <= bus.imm_in;
            state  <= S_ENCODE;
          end
        end

        S_ENCODE: begin
          if (legal) begin
            wdata_q <= word;
            addr_q  <= wr_ptr;
            state   <= S_WRITE;
          end else begin
            state <= S_IDLE;
          end
        end

        S_WRITE: begin
          wr_ptr  <= wr_ptr + 1'b1;
          count_q <= count_q + 1'b1;
          if (count_q == LAST_COUNT) begin
            full_q <= 1'b1;
          end
`ifdef ENC_READBACK_EN
          state <= S_VERIFY;
`else
          state <= S_IDLE;
`endif
        end

`ifdef ENC_READBACK_EN
        S_VERIFY: begin
          state <= S_IDLE;
        end
`endif

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready = ready;
  assign bus.pm_we    = (state == S_WRITE);
  assign bus.pm_addr  = addr_q;
  assign bus.pm_wdata = wdata_q;

  assign err_range = (state == S_ENCODE) && !legal;
  assign full      = full_q;
  assign count     = count_q;

`ifdef ENC_READBACK_EN
  // addr_q still holds the just-written address, so pm_rdata is that word.
  assign err_verify = (state == S_VERIFY) && (bus.pm_rdata != wdata_q);
`else
  logic unused_rdata;
  assign unused_rdata = ^bus.pm_rdata;
  assign err_verify   = 1'b0;
`endif

endmodule

// File: tb/tb_instruction_encoder.sv
module tb_instruction_encoder;

  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DEPTH  = 32;
`ifdef ENC_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset_n;
  logic              clr_addr;
  logic              err_range;
  logic              err_verify;
  logic              full;
  logic [ADDR_W:0]   count;
  logic              corrupt;
  logic [7:0]        mem [DEPTH];

  instruction_encoder_if #(.ADDR_W(ADDR_W)) bus ();

  instruction_encoder #(.ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .clr_addr   (clr_addr),
    .bus        (bus),
    .err_range  (err_range),
    .err_verify (err_verify),
    .full       (full),
    .count      (count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.pm_we === 1'b1) mem[bus.pm_addr] <= bus.pm_wdata;
  end
  assign bus.pm_rdata = mem[bus.pm_addr] ^ (corrupt ? 8'h04 : 8'h00);

  int compared   = 0;
  int mismatched = 0;
  int m_cnt      = 0;
  int m_ptr      = 0;

  typedef struct {
    logic [1:0] f;
    logic [7:0] b;
    logic [7:0] i;
    bit         lg;
    logic [7:0] w;
  } vec_t;

  vec_t vecs [13] = '{
    '{2'd0, 8'hA3, 8'h05, 1'b1, 8'hB7},
    '{2'd2, 8'hC0, 8'hF0, 1'b1, 8'hD0},
    '{2'd2, 8'hC0, 8'h10, 1'b0, 8'h00},
    '{2'd1, 8'h00, 8'h10, 1'b0, 8'h00},
    '{2'd3, 8'h00, 8'h01, 1'b0, 8'h00},
    '{2'd3, 8'h5A, 8'h00, 1'b1, 8'h5A},
    '{2'd0, 8'hFF, 8'h07, 1'b1, 8'hFF},
    '{2'd0, 8'hFF, 8'h08, 1'b0, 8'h00},
    '{2'd1, 8'h3C, 8'h0F, 1'b1, 8'h3F},
    '{2'd2, 8'h1F, 8'h0F, 1'b1, 8'h0F},
    '{2'd2, 8'h1F, 8'hEF, 1'b0, 8'h00},
    '{2'd2, 8'h00, 8'hFF, 1'b1, 8'h1F},
    '{2'd1, 8'h00, 8'hFF, 1'b0, 8'h00}
  };

  // Reference: legality from numeric ranges, word from mask-and-shift.
  function automatic void model(input logic [1:0] f, input logic [7:0] b,
                                input logic [7:0] i, output bit legal,
                                output logic [7:0] w);
    int u;
    int s;
    u = int'(i);
    s = int'($signed(i));
    case (f)
      2'd0: begin legal = (u < 8);  w = 8'((b & 8'hE3) | ((u % 8) * 4)); end
      2'd1: begin legal = (u < 16); w = 8'((b & 8'hF0) | (u % 16)); end
      2'd2: begin legal = (s >= -16 && s <= 15); w = 8'((b & 8'hE0) | (u % 32)); end
      default: begin legal = (u == 0); w = b; end
    endcase
  endfunction

  function automatic logic [7:0] extract(input logic [1:0] f, input logic [7:0] w);
    int v;
    int u;
    u = int'(w);
    case (f)
      2'd0: v = (u / 4) % 8;
      2'd1: v = u % 16;
      2'd2: begin v = u % 32; if (v >= 16) v = v - 32; end
      default: v = 0;
    endcase
    return 8'(v);
  endfunction

  task automatic start_req(input logic [1:0] f, input logic [7:0] b,
                           input logic [7:0] i, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (bus.in_ready === 1'b1) begin ok = 1'b1; break; end
    end
    if (ok) begin
      bus.fmt = f; bus.base = b; bus.imm_in = i; bus.in_valid = 1'b1;
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
    end
  endtask

  task automatic send(input logic [1:0] f, input logic [7:0] b, input logic [7:0] i,
                      output bit ok, output logic err1, output logic we1,
                      output logic we2, output logic [ADDR_W-1:0] a2,
                      output logic [7:0] w2, output logic ev, output logic rdy);
    err1 = 1'b0; we1 = 1'b0; we2 = 1'b0; a2 = '0; w2 = '0; ev = 1'b0; rdy = 1'b0;
    start_req(f, b, i, ok);
    if (ok) begin
      @(negedge clk); err1 = err_range; we1 = bus.pm_we;
      @(negedge clk); we2 = bus.pm_we; a2 = bus.pm_addr; w2 = bus.pm_wdata;
      @(negedge clk); ev = err_verify;
      if (RB) @(negedge clk);
      rdy = bus.in_ready;
    end
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    clr_addr = 1'b1;
    @(negedge clk);
    compared++;
    if (bus.in_ready !== 1'b0) begin
      mismatched++;
      $display("FAIL clr_ready: in_ready=%b expected 0 while clr_addr high", bus.in_ready);
    end
    @(posedge clk);
    #1 clr_addr = 1'b0;
    m_cnt = 0; m_ptr = 0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; clr_addr = 1'b0; corrupt = 1'b0;
    bus.in_valid = 1'b0; bus.fmt = '0; bus.base = '0; bus.imm_in = '0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    m_cnt = 0; m_ptr = 0;
    compared++;
    if ({bus.pm_we, bus.pm_addr, bus.pm_wdata} !== {1'b0, 5'd0, 8'd0}) begin
      mismatched++;
      $display("FAIL reset_bus: we/addr/wdata=%b/%0d/%h expected 0/0/00",
               bus.pm_we, bus.pm_addr, bus.pm_wdata);
    end
    compared++;
    if ({err_range, err_verify, full, count} !== '0) begin
      mismatched++;
      $display("FAIL reset_status: err_range=%b err_verify=%b full=%b count=%0d expected all 0",
               err_range, err_verify, full, count);
    end
    compared++;
    if (bus.in_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL reset_ready: in_ready=%b expected 1", bus.in_ready);
    end
  endtask

  task automatic test_directed();
    bit ok; logic err1, we1, we2, ev, rdy; logic [ADDR_W-1:0] a2; logic [7:0] w2;
    foreach (vecs[n]) begin
      send(vecs[n].f, vecs[n].b, vecs[n].i, ok, err1, we1, we2, a2, w2, ev, rdy);
      compared++;
      if (ok !== 1'b1) begin
        mismatched++;
        $display("FAIL dir%0d_handshake: in_ready timeout, expected ready", n);
        continue;
      end
      compared++;
      if ({err1, we1, we2} !== {!vecs[n].lg, 1'b0, vecs[n].lg}) begin
        mismatched++;
        $display("FAIL dir%0d_ctrl: err_range/we_enc/we_wr=%b%b%b expected %b0%b",
                 n, err1, we1, we2, !vecs[n].lg, vecs[n].lg);
      end
      if (vecs[n].lg) begin
        compared++;
        if ({a2, w2} !== {ADDR_W'(m_ptr), vecs[n].w}) begin
          mismatched++;
          $display("FAIL dir%0d_word: addr=%0d wdata=%h expected addr=%0d wdata=%h",
                   n, a2, w2, m_ptr, vecs[n].w);
        end
        m_cnt++; m_ptr = (m_ptr + 1) % DEPTH;
      end
      compared++;
      if ({count, ev, rdy} !== {(ADDR_W+1)'(m_cnt), 1'b0, 1'b1}) begin
        mismatched++;
        $display("FAIL dir%0d_after: count=%0d err_verify=%b in_ready=%b expected %0d/0/1",
                 n, count, ev, rdy, m_cnt);
      end
    end
  endtask

  task automatic test_random();
    bit ok, lg; logic err1, we1, we2, ev, rdy; logic [ADDR_W-1:0] a2;
    logic [7:0] w2, ew, b, i; logic [1:0] f;
    for (int n = 0; n < 60; n++) begin
      if (m_cnt >= int'(DEPTH) - 2) pulse_clr();
      f = 2'($urandom_range(0, 3));
      b = 8'($urandom);
      if ($urandom_range(0, 2) == 0) i = 8'($urandom);
      else begin
        case (f)
          2'd0: i = 8'($urandom_range(0, 7));
          2'd1: i = 8'($urandom_range(0, 15));
          2'd2: i = 8'(int'($urandom_range(0, 31)) - 16);
          default: i = 8'd0;
        endcase
      end
      model(f, b, i, lg, ew);
      send(f, b, i, ok, err1, we1, we2, a2, w2, ev, rdy);
      compared++;
      if (ok !== 1'b1) begin
        mismatched++;
        $display("FAIL rnd%0d_handshake: in_ready timeout, expected ready", n);
        continue;
      end
      compared++;
      if ({err1, we1, we2} !== {!lg, 1'b0, lg}) begin
        mismatched++;
        $display("FAIL rnd%0d_ctrl: fmt=%0d imm=%h err_range/we_enc/we_wr=%b%b%b expected %b0%b",
                 n, f, i, err1, we1, we2, !lg, lg);
      end
      if (lg) begin
        compared++;
        if ({a2, w2} !== {ADDR_W'(m_ptr), ew}) begin
          mismatched++;
          $display("FAIL rnd%0d_word: addr=%0d wdata=%h expected addr=%0d wdata=%h",
                   n, a2, w2, m_ptr, ew);
        end
        compared++;
        if (extract(f, w2) !== i) begin
          mismatched++;
          $display("FAIL rnd%0d_roundtrip: extracted %h expected %h", n, extract(f, w2), i);
        end
        m_cnt++; m_ptr = (m_ptr + 1) % DEPTH;
      end
      compared++;
      if ({count, ev} !== {(ADDR_W+1)'(m_cnt), 1'b0}) begin
        mismatched++;
        $display("FAIL rnd%0d_count: count=%0d err_verify=%b expected %0d/0", n, count, ev, m_cnt);
      end
    end
  endtask

  task automatic test_full();
    bit ok; logic err1, we1, we2, ev, rdy; logic [ADDR_W-1:0] a2; logic [7:0] w2, i;
    pulse_clr();
    for (int n = 0; n < int'(DEPTH); n++) begin
      i = 8'($urandom_range(0, 15));
      send(2'd1, 8'($urandom), i, ok, err1, we1, we2, a2, w2, ev, rdy);
      if (ok) begin m_cnt++; m_ptr = (m_ptr + 1) % DEPTH; end
      compared++;
      if ({ok, we2, a2, full} !== {1'b1, 1'b1, ADDR_W'(n), m_cnt == int'(DEPTH)}) begin
        mismatched++;
        $display("FAIL full%0d_write: ok=%b we=%b addr=%0d full=%b expected 1/1/%0d/%b",
                 n, ok, we2, a2, full, n, m_cnt == int'(DEPTH));
      end
    end
    @(negedge clk);
    compared++;
    if ({full, count, bus.in_ready} !== {1'b1, 6'd32, 1'b0}) begin
      mismatched++;
      $display("FAIL full_state: full=%b count=%0d in_ready=%b expected 1/32/0",
               full, count, bus.in_ready);
    end
    pulse_clr();
    @(negedge clk);
    compared++;
    if ({full, count, bus.in_ready} !== {1'b0, 6'd0, 1'b1}) begin
      mismatched++;
      $display("FAIL full_clr: full=%b count=%0d in_ready=%b expected 0/0/1",
               full, count, bus.in_ready);
    end
    send(2'd0, 8'h00, 8'h03, ok, err1, we1, we2, a2, w2, ev, rdy);
    m_cnt = 1; m_ptr = 1;
    compared++;
    if ({ok, we2, a2, w2, count} !== {1'b1, 1'b1, 5'd0, 8'h0C, 6'd1}) begin
      mismatched++;
      $display("FAIL full_after_clr: ok=%b we=%b addr=%0d wdata=%h count=%0d expected 1/1/0/0c/1",
               ok, we2, a2, w2, count);
    end
  endtask

  task automatic test_clr_pending();
    bit ok; logic err1, we1, we2, ev, rdy; logic [ADDR_W-1:0] a2; logic [7:0] w2;
    start_req(2'd1, 8'h20, 8'h05, ok);
    @(negedge clk);
    @(negedge clk);
    clr_addr = 1'b1;
    @(posedge clk);
    #1 clr_addr = 1'b0;
    repeat (3) @(negedge clk);
    m_cnt = 0; m_ptr = 0;
    compared++;
    if ({ok, count, full} !== {1'b1, 6'd0, 1'b0}) begin
      mismatched++;
      $display("FAIL clr_pending: ok=%b count=%0d full=%b expected 1/0/0", ok, count, full);
    end
    send(2'd3, 8'h77, 8'h00, ok, err1, we1, we2, a2, w2, ev, rdy);
    m_cnt = 1; m_ptr = 1;
    compared++;
    if ({ok, we2, a2, w2} !== {1'b1, 1'b1, 5'd0, 8'h77}) begin
      mismatched++;
      $display("FAIL clr_pending_next: ok=%b we=%b addr=%0d wdata=%h expected 1/1/0/77",
               ok, we2, a2, w2);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    start_req(2'd2, 8'h40, 8'h03, ok);
    @(negedge clk);
    @(negedge clk);
    compared++;
    if ({ok, bus.pm_we} !== 2'b11) begin
      mismatched++;
      $display("FAIL rstmid_write: ok=%b pm_we=%b expected 1/1 in write cycle", ok, bus.pm_we);
    end
    reset_n = 1'b0;
    @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    m_cnt = 0; m_ptr = 0;
    compared++;
    if ({bus.pm_we, count, full, bus.in_ready} !== {1'b0, 6'd0, 1'b0, 1'b1}) begin
      mismatched++;
      $display("FAIL rstmid_after: pm_we=%b count=%0d full=%b in_ready=%b expected 0/0/0/1",
               bus.pm_we, count, full, bus.in_ready);
    end
  endtask

  task automatic test_readback();
    bit ok; logic err1, we1, we2, ev, rdy; logic [ADDR_W-1:0] a2; logic [7:0] w2;
    corrupt = 1'b1;
    send(2'd0, 8'h81, 8'h06, ok, err1, we1, we2, a2, w2, ev, rdy);
    corrupt = 1'b0;
    compared++;
    if ({ok, we2, ev} !== {1'b1, 1'b1, RB}) begin
      mismatched++;
      $display("FAIL readback_corrupt: ok=%b we=%b err_verify=%b expected 1/1/%b",
               ok, we2, ev, RB);
    end
    send(2'd0, 8'h81, 8'h06, ok, err1, we1, we2, a2, w2, ev, rdy);
    compared++;
    if ({ok, we2, ev, rdy} !== 4'b1101) begin
      mismatched++;
      $display("FAIL readback_clean: ok=%b we=%b err_verify=%b in_ready=%b expected 1/1/0/1",
               ok, we2, ev, rdy);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_full();
    test_clr_pending();
    test_reset_mid();
    test_readback();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
